// File: rtl/handshake_const_checker_if.sv
// Token channel into the constant checker: data word plus valid/ready handshake.
// master drives ins/ins_valid, slave (the checker) drives ins_ready.
interface handshake_const_checker_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] ins;
   logic                  ins_valid;
   logic                  ins_ready;

   modport master (output ins, output ins_valid, input  ins_ready);
   modport slave  (input  ins, input  ins_valid, output ins_ready);
endinterface

// File: rtl/handshake_const_checker.sv
// Handshake sink that checks every token against a constant and keeps statistics.
// Optional CHECKER_STALL_EN adds LFSR-driven pseudo-random backpressure on the slot.
module handshake_const_checker #(
   parameter int unsigned           DATA_WIDTH    = 32,
   parameter logic [DATA_WIDTH-1:0] EXPECTED      = 'h0A9C77,
   parameter int unsigned           CNT_WIDTH     = 16,
   parameter int unsigned           EXPECT_TOKENS = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   handshake_const_checker_if.slave     chan,
   output logic [CNT_WIDTH-1:0]         tok_count,
   output logic [CNT_WIDTH-1:0]         err_count,
   output logic                         err_flag,
   output logic [DATA_WIDTH-1:0]        first_err_data,
   output logic [CNT_WIDTH-1:0]         first_err_idx,
   output logic                         done
);

   typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic                   full_q, full_d;
   logic [DATA_WIDTH-1:0]  slot_q, slot_d;
   logic [CNT_WIDTH-1:0]   tok_count_q, tok_count_d;
   logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;
   logic                   err_flag_q, err_flag_d;
   logic [DATA_WIDTH-1:0]  first_err_data_q, first_err_data_d;
   logic [CNT_WIDTH-1:0]   first_err_idx_q, first_err_idx_d;

   logic stall;
   logic drain;
   logic accept;
   logic mismatch;

`ifdef CHECKER_STALL_EN
   logic [7:0] lfsr_q, lfsr_d;

   // Fibonacci taps 8,6,5,4; reseeded on clear so a cleared run repeats its stall pattern
   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (clear) begin
         lfsr_d = 8'hA5;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= 8'hA5;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign stall = lfsr_q[0] & lfsr_q[1];
`else
   assign stall = 1'b0;
`endif

   assign drain    = full_q && !stall;
   assign accept   = chan.ins_valid && chan.ins_ready;
   assign mismatch = (slot_q != EXPECTED);

   // Statistics update; clear wins over a same-cycle check
   always_comb begin
      tok_count_d      = tok_count_q;
      err_count_d      = err_count_q;
      err_flag_d       = err_flag_q;
      first_err_data_d = first_err_data_q;
      first_err_idx_d  = first_err_idx_q;
      if (clear) begin
         tok_count_d      = '0;
         err_count_d      = '0;
         err_flag_d       = 1'b0;
         first_err_data_d = '0;
         first_err_idx_d  = '0;
      end else if (drain) begin
         if (tok_count_q != '1) begin
            tok_count_d = tok_count_q + CNT_WIDTH'(1);
         end
         if (mismatch) begin
            if (err_count_q != '1) begin
               err_count_d = err_count_q + CNT_WIDTH'(1);
            end
            err_flag_d = 1'b1;
            if (!err_flag_q) begin
               first_err_data_d = slot_q;
               first_err_idx_d  = tok_count_q;
            end
         end
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = RUN;
      end else if (state_q == RUN && drain && EXPECT_TOKENS != 0 &&
                   32'(tok_count_d) == EXPECT_TOKENS) begin
         state_d = DONE;
      end
   end

   // Input slot; a token accepted on the finishing edge is dropped since DONE holds no token
   always_comb begin
      full_d = full_q;
      slot_d = slot_q;
      if (clear) begin
         full_d = 1'b0;
         slot_d = '0;
      end else begin
         if (drain) begin
            full_d = 1'b0;
         end
         if (accept) begin
            full_d = 1'b1;
            slot_d = chan.ins;
         end
         if (state_d == DONE) begin
            full_d = 1'b0;
         end
      end
   end

   // FSM outputs; ready is also forced low while reset is asserted
   always_comb begin
      chan.ins_ready = rst && (state_q == RUN) && !clear && (!full_q || drain);
      done           = (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= RUN;
         full_q           <= 1'b0;
         slot_q           <= '0;
         tok_count_q      <= '0;
         err_count_q      <= '0;
         err_flag_q       <= 1'b0;
         first_err_data_q <= '0;
         first_err_idx_q  <= '0;
      end else begin
         state_q          <= state_d;
         full_q           <= full_d;
         slot_q           <= slot_d;
         tok_count_q      <= tok_count_d;
         err_count_q      <= err_count_d;
         err_flag_q       <= err_flag_d;
         first_err_data_q <= first_err_data_d;
         first_err_idx_q  <= first_err_idx_d;
      end
   end

   assign tok_count      = tok_count_q;
   assign err_count      = err_count_q;
   assign err_flag       = err_flag_q;
   assign first_err_data = first_err_data_q;
   assign first_err_idx  = first_err_idx_q;

endmodule

// File: tb/tb_handshake_const_checker.sv
// Bench for handshake_const_checker: three instances (default, EXPECT_TOKENS=3, CNT_WIDTH=4)
// share one token stream and are checked every cycle against a token-list model.
module tb_handshake_const_checker;

   localparam logic [31:0] EXPW = 32'h000A9C77;
   localparam int NDUT = 3;
`ifdef CHECKER_STALL_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        clear = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] data  = '0;

   int n_vec  = 0;
   int n_miss = 0;
   int n_tx   = 0;

   always #5 clk = ~clk;

   handshake_const_checker_if #(.DATA_WIDTH(32)) if_a ();
   handshake_const_checker_if #(.DATA_WIDTH(32)) if_b ();
   handshake_const_checker_if #(.DATA_WIDTH(32)) if_c ();

   assign if_a.ins = data;  assign if_a.ins_valid = valid;
   assign if_b.ins = data;  assign if_b.ins_valid = valid;
   assign if_c.ins = data;  assign if_c.ins_valid = valid;

   logic [15:0] tok_a, err_a, fidx_a;
   logic [15:0] tok_b, err_b, fidx_b;
   logic [3:0]  tok_c, err_c, fidx_c;
   logic [31:0] fdat_a, fdat_b, fdat_c;
   logic        flag_a, flag_b, flag_c;
   logic        done_a, done_b, done_c;

   handshake_const_checker u_main (
      .clk(clk), .rst(rst), .clear(clear), .chan(if_a.slave),
      .tok_count(tok_a), .err_count(err_a), .err_flag(flag_a),
      .first_err_data(fdat_a), .first_err_idx(fidx_a), .done(done_a));

   handshake_const_checker #(.EXPECT_TOKENS(3)) u_done (
      .clk(clk), .rst(rst), .clear(clear), .chan(if_b.slave),
      .tok_count(tok_b), .err_count(err_b), .err_flag(flag_b),
      .first_err_data(fdat_b), .first_err_idx(fidx_b), .done(done_b));

   handshake_const_checker #(.CNT_WIDTH(4)) u_sat (
      .clk(clk), .rst(rst), .clear(clear), .chan(if_c.slave),
      .tok_count(tok_c), .err_count(err_c), .err_flag(flag_c),
      .first_err_data(fdat_c), .first_err_idx(fidx_c), .done(done_c));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: unsaturated token/error tallies, saturated on output
   int          m_chk  [NDUT];
   int          m_bad  [NDUT];
   int          m_fidx [NDUT];
   bit          m_pend [NDUT];
   bit          m_done [NDUT];
   logic [31:0] m_pdata[NDUT];
   logic [31:0] m_fdata[NDUT];
   logic [7:0]  m_lfsr [NDUT];

   function automatic int cnt_max(input int k);
      return (k == 2) ? 15 : 65535;
   endfunction

   function automatic int target(input int k);
      return (k == 1) ? 3 : 0;
   endfunction

   function automatic int sat(input int x, input int k);
      return (x > cnt_max(k)) ? cnt_max(k) : x;
   endfunction

   function automatic bit m_stall(input int k);
      return STALL_EN && m_lfsr[k][0] && m_lfsr[k][1];
   endfunction

   function automatic bit exp_ready(input int k);
      return rst && !m_done[k] && !clear && (!m_pend[k] || !m_stall(k));
   endfunction

   task automatic m_clear(input int k);
      m_chk[k] = 0;  m_bad[k] = 0;  m_fidx[k] = 0;
      m_pend[k] = 0; m_done[k] = 0;
      m_pdata[k] = '0; m_fdata[k] = '0;
      m_lfsr[k] = 8'hA5;
   endtask

   task automatic m_step(input int k);
      bit st;
      bit acc;
      st  = m_stall(k);
      acc = valid && exp_ready(k);
      if (clear) begin
         m_clear(k);
      end else begin
         if (m_pend[k] && !st) begin
            if (m_pdata[k] != EXPW) begin
               if (m_bad[k] == 0) begin
                  m_fdata[k] = m_pdata[k];
                  m_fidx[k]  = sat(m_chk[k], k);
               end
               m_bad[k]++;
            end
            m_chk[k]++;
            m_pend[k] = 0;
            if (target(k) != 0 && sat(m_chk[k], k) == target(k)) m_done[k] = 1;
         end
         if (acc) begin
            m_pend[k]  = 1;
            m_pdata[k] = data;
         end
         if (m_done[k]) m_pend[k] = 0;
         m_lfsr[k] = {m_lfsr[k][6:0], m_lfsr[k][7] ^ m_lfsr[k][5] ^ m_lfsr[k][4] ^ m_lfsr[k][3]};
      end
   endtask

   initial begin
      for (int k = 0; k < NDUT; k++) m_clear(k);
      forever begin
         @(posedge clk or negedge rst);
         for (int k = 0; k < NDUT; k++) begin
            if (!rst) m_clear(k);
            else      m_step(k);
         end
      end
   end

   // ---------------- per-cycle compare
   task automatic cmp_dut(input int k, input logic rdy, input logic [31:0] tok,
                          input logic [31:0] err, input logic flg, input logic [31:0] fd,
                          input logic [31:0] fi, input logic dn);
      check($sformatf("ready[%0d]", k),          32'(rdy), 32'(exp_ready(k)));
      check($sformatf("tok_count[%0d]", k),      tok, 32'(sat(m_chk[k], k)));
      check($sformatf("err_count[%0d]", k),      err, 32'(sat(m_bad[k], k)));
      check($sformatf("err_flag[%0d]", k),       32'(flg), 32'(m_bad[k] > 0));
      check($sformatf("first_err_data[%0d]", k), fd, m_fdata[k]);
      check($sformatf("first_err_idx[%0d]", k),  fi, 32'(m_fidx[k]));
      check($sformatf("done[%0d]", k),           32'(dn), 32'(m_done[k]));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cmp_dut(0, if_a.ins_ready, 32'(tok_a), 32'(err_a), flag_a, fdat_a, 32'(fidx_a), done_a);
         cmp_dut(1, if_b.ins_ready, 32'(tok_b), 32'(err_b), flag_b, fdat_b, 32'(fidx_b), done_b);
         cmp_dut(2, if_c.ins_ready, 32'(tok_c), 32'(err_c), flag_c, fdat_c, 32'(fidx_c), done_c);
      end
   end

   // ---------------- stimulus
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one token, handshaking against u_main's ready
   task automatic send(input logic [31:0] d);
      int  n;
      bit  took;
      n     = 0;
      took  = 1'b0;
      valid = 1'b1;
      data  = d;
      do begin
         @(negedge clk);
         took = if_a.ins_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!took && n < 50);
      check("send_handshake", 32'(took), 32'd1);
      n_tx++;
      $display("tx %0d: data=%h accepted after %0d cycle(s)", n_tx, d, n);
      valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
   endtask

   initial begin
      int low;
      #1 rst = 1'b0;
      tick(3);
      check("reset_tok_count", 32'(tok_a), 32'd0);
      check("reset_ready_low", 32'(if_a.ins_ready), 32'd0);
      check("reset_err_flag", 32'(flag_a), 32'd0);
      check("reset_done", 32'(done_b), 32'd0);
      rst = 1'b1;
      tick(1);
      check("idle_ready", 32'(if_a.ins_ready), 32'd1);

      // 10 good tokens back to back
      for (int i = 0; i < 10; i++) send(EXPW);
      tick(10);
      check("p1_tok_count", 32'(tok_a), 32'd10);
      check("p1_err_count", 32'(err_a), 32'd0);
      check("p1_err_flag", 32'(flag_a), 32'd0);
      check("p1_done_tok", 32'(tok_b), 32'd3);
      check("p1_done", 32'(done_b), 32'd1);

      // mixed tokens, first error at index 1
      pulse_clear();
      send(EXPW);
      send(32'h000A9C76);
      send(EXPW);
      check("p2_done_before_check", 32'(done_b), 32'd0);
`ifndef CHECKER_STALL_EN
      tick(1);
      check("p2_done_one_edge_later", 32'(done_b), 32'd1);
      check("p2_done_ready_low", 32'(if_b.ins_ready), 32'd0);
`endif
      send(32'h0);
      tick(10);
      check("p2_tok_count", 32'(tok_a), 32'd4);
      check("p2_err_count", 32'(err_a), 32'd2);
      check("p2_first_err_data", fdat_a, 32'h000A9C76);
      check("p2_first_err_idx", 32'(fidx_a), 32'd1);
      check("p2_err_flag", 32'(flag_a), 32'd1);
      send(EXPW);
      tick(10);
      check("p2_done_tok", 32'(tok_b), 32'd3);
      check("p2_done", 32'(done_b), 32'd1);
      check("p2_done_err", 32'(err_b), 32'd1);

      // saturation on the 4-bit instance
      pulse_clear();
      for (int i = 0; i < 20; i++) send(32'h0);
      tick(10);
      check("p3_sat_tok", 32'(tok_c), 32'd15);
      check("p3_sat_err", 32'(err_c), 32'd15);
      check("p3_sat_flag", 32'(flag_c), 32'd1);
      check("p3_sat_fidx", 32'(fidx_c), 32'd0);
      check("p3_main_tok", 32'(tok_a), 32'd20);

      // clear with a token in the slot
      pulse_clear();
      send(32'h000A9C76);
      pulse_clear();
      check("p4_tok_after_clear", 32'(tok_a), 32'd0);
      check("p4_err_after_clear", 32'(err_a), 32'd0);
      check("p4_flag_after_clear", 32'(flag_a), 32'd0);
      send(32'h1);
      tick(10);
      check("p4_tok", 32'(tok_a), 32'd1);
      check("p4_err", 32'(err_a), 32'd1);
      check("p4_fidx", 32'(fidx_a), 32'd0);
      check("p4_fdata", fdat_a, 32'h1);

      // streaming, then asynchronous reset mid-stream
      valid = 1'b1;
      data  = EXPW;
      low   = 0;
      repeat (100) begin
         @(negedge clk);
         if (!if_a.ins_ready) low++;
      end
`ifdef CHECKER_STALL_EN
      check("p5_ready_low_ratio", 32'(low >= 8 && low <= 50), 32'd1);
`else
      check("p5_ready_low_cycles", 32'(low), 32'd0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("p5_rst_tok", 32'(tok_a), 32'd0);
      check("p5_rst_ready", 32'(if_a.ins_ready), 32'd0);
      check("p5_rst_done", 32'(done_b), 32'd0);
      check("p5_rst_sat_tok", 32'(tok_c), 32'd0);
      valid = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
      for (int i = 0; i < 8; i++) send((i % 2 == 1) ? 32'h100 + 32'(i) : EXPW);
      tick(10);
      check("p5_tok", 32'(tok_a), 32'd8);
      check("p5_err", 32'(err_a), 32'd4);
      check("p5_fidx", 32'(fidx_a), 32'd1);
      check("p5_fdata", fdat_a, 32'h101);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
